// File: rtl/lc3_pkg.sv
// Shared LC-3 decode definitions: opcodes, control encodings and the
// combinational instruction decoder used by the decode stage.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_RTI = 4'b1000;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_RES = 4'b1101;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } alu_e;

  typedef enum logic [1:0] {
    PC1_NONE = 2'b00,
    PC1_OFF9 = 2'b01,
    PC1_OFF6 = 2'b10,
    PC1_ZERO = 2'b11
  } pcsel1_e;

  typedef enum logic [1:0] {
    W_ALU   = 2'b00,
    W_PCREL = 2'b01,
    W_MEM   = 2'b10
  } wsel_e;

  typedef struct packed {
    logic [5:0] e_control;   // {alu, pcsel1, pcsel2, op2sel}
    logic [1:0] w_control;
    logic       mem_control;
    logic       illegal;
  } decode_t;

  function automatic decode_t lc3_decode(input logic [15:0] instr);
    decode_t d;
    alu_e    alu;
    pcsel1_e pc1;
    logic    pc2;
    logic    op2;
    d   = '0;
    alu = ALU_PASS;
    pc1 = PC1_NONE;
    pc2 = 1'b0;
    op2 = 1'b0;
    case (instr[15:12])
      OP_ADD: begin alu = ALU_ADD; op2 = !instr[5]; end
      OP_AND: begin alu = ALU_AND; op2 = !instr[5]; end
      OP_NOT: begin alu = ALU_NOT; op2 = !instr[5]; end
      OP_LD, OP_LDI: begin
        d.w_control   = W_MEM;
        pc1           = PC1_OFF9;
        pc2           = 1'b1;
        d.mem_control = (instr[15:12] == OP_LDI);
      end
      OP_LDR: begin d.w_control = W_MEM; pc1 = PC1_OFF6; end
      OP_LEA: begin d.w_control = W_PCREL; pc1 = PC1_OFF9; pc2 = 1'b1; end
      OP_ST, OP_STI: begin
        pc1           = PC1_OFF9;
        pc2           = 1'b1;
        d.mem_control = (instr[15:12] == OP_STI);
      end
      OP_STR: pc1 = PC1_OFF6;
      OP_BR:  begin pc1 = PC1_OFF9; pc2 = 1'b1; end
      OP_JMP: pc1 = PC1_ZERO;
      OP_RTI, OP_RES: d.illegal = 1'b1;
      default: ;
    endcase
    d.e_control = {alu, pc1, pc2, op2};
    return d;
  endfunction

endpackage

// File: rtl/lc3_instr_fifo.sv
// Instruction queue: DEPTH-entry circular buffer with explicit occupancy
// count so full and empty stay unambiguous when the pointers coincide.
module lc3_instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW:0]    FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];
  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty && !flush;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW + 1)'(wr_en) - (PW + 1)'(rd_en);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/lc3_decode_queue.sv
// LC-3 decode stage: instruction queue feeding a registered decode bundle
// with valid/ready on both sides and a flush for branch redirects.
module lc3_decode_queue
  import lc3_pkg::*;
#(
  parameter int NPC_W  = 16,
  parameter int DEPTH  = 4,
  parameter bit EN_ILL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instr_dout,
  input  logic [NPC_W-1:0] npc_in,
  input  logic [2:0]       psr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      IR,
  output logic [NPC_W-1:0] npc_out,
  output logic [5:0]       E_control,
  output logic [1:0]       W_control,
  output logic             Mem_Control,
  output logic             br_taken,
  output logic             illegal
);

  localparam int WIDTH = 16 + NPC_W;

  logic             fifo_full, fifo_empty, push, pop;
  logic [WIDTH-1:0] head;
  logic [15:0]      head_ir;
  logic [NPC_W-1:0] head_npc;
  decode_t          dec;
  logic             head_br;

  logic             out_valid_q, out_valid_d;
  logic [15:0]      ir_q, ir_d;
  logic [NPC_W-1:0] npc_q, npc_d;
  decode_t          bundle_q, bundle_d;
  logic             br_q, br_d;

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full && !flush;
  assign pop      = !fifo_empty && (!out_valid_q || out_ready) && !flush;
  assign head_ir  = head[WIDTH-1 -: 16];
  assign head_npc = head[NPC_W-1:0];
  assign dec      = lc3_decode(head_ir);

  lc3_instr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({instr_dout, npc_in}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Branch condition uses psr as it stands on the cycle the word leaves the queue.
  always_comb begin
    head_br = 1'b0;
    if (head_ir[15:12] == OP_BR)       head_br = |(head_ir[11:9] & psr);
    else if (head_ir[15:12] == OP_JMP) head_br = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    ir_d        = ir_q;
    npc_d       = npc_q;
    bundle_d    = bundle_q;
    br_d        = br_q;
    if (pop) begin
      out_valid_d      = 1'b1;
      ir_d             = head_ir;
      npc_d            = head_npc;
      bundle_d         = dec;
      bundle_d.illegal = dec.illegal && EN_ILL;
      br_d             = head_br;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      ir_q        <= '0;
      npc_q       <= '0;
      bundle_q    <= '0;
      br_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      ir_q        <= ir_d;
      npc_q       <= npc_d;
      bundle_q    <= bundle_d;
      br_q        <= br_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign IR          = ir_q;
  assign npc_out     = npc_q;
  assign E_control   = bundle_q.e_control;
  assign W_control   = bundle_q.w_control;
  assign Mem_Control = bundle_q.mem_control;
  assign illegal     = bundle_q.illegal;
  assign br_taken    = br_q;

endmodule
